spi_txn_arbiter: RTL and testbench

SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

---
 rtl/spi_txn_arbiter_if.sv | 37 +++
 rtl/spi_txn_arbiter.sv | 154 +++++++++++++++
 tb/tb_spi_txn_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_txn_arbiter_if.sv
// Request/response and SPI-engine signal bundle for spi_txn_arbiter.
// The slave modport is the arbiter's view; master is the requester/engine view.
interface spi_txn_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req0_cmd;
    logic [7:0]  req1_cmd;
    logic [23:0] req0_addr;
    logic [23:0] req1_addr;
    logic [31:0] req0_data;
    logic [31:0] req1_data;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_err;
    logic        spi_start;
    logic        we;
    logic [7:0]  spi_cmd;
    logic [23:0] spi_addr;
    logic [31:0] spi_data;
    logic        data_end;
    logic        crc_ok;
    logic [31:0] spi_resp;

    modport slave (
        input  req_valid, req0_cmd, req1_cmd, req0_addr, req1_addr,
        input  req0_data, req1_data, data_end, crc_ok, spi_resp,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output spi_start, we, spi_cmd, spi_addr, spi_data
    );

    modport master (
        output req_valid, req0_cmd, req1_cmd, req0_addr, req1_addr,
        output req0_data, req1_data, data_end, crc_ok, spi_resp,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  spi_start, we, spi_cmd, spi_addr, spi_data
    );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Two-requester round-robin arbiter in front of an SPI transaction engine,
// with CRC-driven retry, completion timeout and per-owner response strobes.
module spi_txn_arbiter #(
    parameter int unsigned MAX_RETRY = 2,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic             clk,
    input  logic             rst,
    spi_txn_arbiter_if.slave arb_if
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    localparam logic [2:0]  MAX_RETRY_W = 3'(MAX_RETRY);
    localparam logic [16:0] TIMEOUT_W   = 17'(TIMEOUT);

    state_e      state_q;
    logic        rr_q;
    logic        owner_q;
    logic [2:0]  retry_q;
    logic [15:0] wait_cnt_q;
    logic        data_end_q;
    logic        crc_q;
    logic [31:0] resp_q;
    logic [7:0]  cmd_q;
    logic [23:0] addr_q;
    logic [31:0] data_q;
    logic        spi_start_q;
    logic [1:0]  rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic [1:0]  rsp_err_q;

    logic [1:0]  grant_d;
    logic        done_d;
    logic        expire_d;

    // Round-robin grant, offered only while idle and out of reset.
    always_comb begin
        grant_d = 2'b00;
        if (state_q == ST_IDLE && !rst) begin
            case (arb_if.req_valid)
                2'b01:   grant_d = 2'b01;
                2'b10:   grant_d = 2'b10;
                2'b11:   grant_d = rr_q ? 2'b10 : 2'b01;
                default: grant_d = 2'b00;
            endcase
        end else begin
            grant_d = 2'b00;
        end
    end

    // Completion is a rising edge of data_end seen while waiting; a level already high does not count.
    always_comb begin
        done_d   = (state_q == ST_WAIT) && arb_if.data_end && !data_end_q;
        expire_d = (({1'b0, wait_cnt_q} + 17'd1) >= TIMEOUT_W);
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_q        <= 1'b0;
            owner_q     <= 1'b0;
            retry_q     <= 3'd0;
            wait_cnt_q  <= 16'd0;
            data_end_q  <= 1'b0;
            crc_q       <= 1'b0;
            resp_q      <= 32'd0;
            cmd_q       <= 8'd0;
            addr_q      <= 24'd0;
            data_q      <= 32'd0;
            spi_start_q <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= 32'd0;
            rsp_err_q   <= 2'b00;
        end else begin
            data_end_q  <= arb_if.data_end;
            spi_start_q <= 1'b0;
            rsp_valid_q <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (grant_d != 2'b00) begin
                        owner_q     <= grant_d[1];
                        rr_q        <= ~grant_d[1];
                        cmd_q       <= grant_d[1] ? arb_if.req1_cmd  : arb_if.req0_cmd;
                        addr_q      <= grant_d[1] ? arb_if.req1_addr : arb_if.req0_addr;
                        data_q      <= grant_d[1] ? arb_if.req1_data : arb_if.req0_data;
                        retry_q     <= 3'd0;
                        spi_start_q <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt_q <= 16'd0;
                    state_q    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done_d) begin
                        resp_q  <= arb_if.spi_resp;
                        crc_q   <= arb_if.crc_ok;
                        state_q <= ST_CHECK;
                    end else if (expire_d) begin
                        rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                        rsp_data_q  <= 32'd0;
                        rsp_err_q   <= 2'b10;
                        state_q     <= ST_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                    end
                end
                ST_CHECK: begin
                    if (crc_q) begin
                        rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                        rsp_data_q  <= resp_q;
                        rsp_err_q   <= 2'b00;
                        state_q     <= ST_RESP;
                    end else if (retry_q < MAX_RETRY_W) begin
                        retry_q     <= retry_q + 3'd1;
                        spi_start_q <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end else begin
                        rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                        rsp_data_q  <= resp_q;
                        rsp_err_q   <= 2'b01;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign arb_if.req_ready = grant_d;
    assign arb_if.rsp_valid = rsp_valid_q;
    assign arb_if.rsp_data  = rsp_data_q;
    assign arb_if.rsp_err   = rsp_err_q;
    assign arb_if.spi_start = spi_start_q;
    assign arb_if.we        = spi_start_q;
    assign arb_if.spi_cmd   = cmd_q;
    assign arb_if.spi_addr  = addr_q;
    assign arb_if.spi_data  = data_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Randomized scoreboard bench for spi_txn_arbiter: a driver predicts grants and
// responses from the arbitration/retry rules, an engine model answers launches, a monitor checks responses.
module tb_spi_txn_arbiter;
    localparam int MAX_RETRY = 2;
    localparam int TIMEOUT   = 16;

    typedef struct {
        logic        owner;
        logic [31:0] data;
        logic [1:0]  err;
        int          issues;
        logic [7:0]  cmd;
        logic [23:0] addr;
        logic [31:0] wdata;
        bit          tmo;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   issue_cnt = 0;
    int   first_start_cyc = -1;
    int   last_start_cyc = 0;
    bit   mon_en = 1'b0;
    bit   eng_en = 1'b0;
    bit   rr_m = 1'b0;

    logic [7:0]  cur_cmd = 8'd0;
    logic [23:0] cur_addr = 24'd0;
    logic [31:0] cur_data = 32'd0;
    int          cur_fail = 0;
    int          cur_delay = 2;
    bit          cur_tmo = 1'b0;
    bit          cur_stale = 1'b0;

    exp_t sb_q[$];

    spi_txn_arbiter_if arb_if ();

    spi_txn_arbiter #(.MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .rst    (rst),
        .arb_if (arb_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 64'(arb_if.req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(arb_if.rsp_valid), 64'd0);
        chk({tag, "_rsp"}, 64'({arb_if.rsp_err, arb_if.rsp_data}), 64'd0);
        chk({tag, "_start_we"}, 64'({arb_if.spi_start, arb_if.we}), 64'd0);
        chk({tag, "_fields"}, {arb_if.spi_cmd, arb_if.spi_addr, arb_if.spi_data}, 64'd0);
    endtask

    // Engine model: answers each launch with a loopback of spi_data after a delay.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (eng_en && arb_if.spi_start === 1'b1) begin
                issue_cnt++;
                if (issue_cnt == 1) first_start_cyc = cyc;
                last_start_cyc = cyc;
                chk("we_with_start", 64'(arb_if.we), 64'd1);
                chk("spi_fields", {arb_if.spi_cmd, arb_if.spi_addr, arb_if.spi_data},
                    {cur_cmd, cur_addr, cur_data});
                if (!cur_tmo) begin
                    if (cur_stale) begin
                        arb_if.data_end = 1'b1;
                        arb_if.spi_resp = 32'h0BAD0BAD;
                        arb_if.crc_ok   = 1'b1;
                        repeat (3) @(negedge clk);
                        arb_if.data_end = 1'b0;
                        repeat (2) @(negedge clk);
                    end else begin
                        repeat (cur_delay) @(negedge clk);
                    end
                    arb_if.data_end = 1'b1;
                    arb_if.spi_resp = arb_if.spi_data;
                    arb_if.crc_ok   = (issue_cnt > cur_fail);
                    @(negedge clk);
                    arb_if.data_end = 1'b0;
                    arb_if.crc_ok   = 1'($urandom);
                    arb_if.spi_resp = $urandom;
                end
            end
        end
    end

    // Monitor: every response strobe is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (mon_en && arb_if.rsp_valid !== 2'b00) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp actual=%b expected=00", arb_if.rsp_valid);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_owner", 64'(arb_if.rsp_valid), e.owner ? 64'd2 : 64'd1);
                    chk("rsp_data", 64'(arb_if.rsp_data), 64'(e.data));
                    chk("rsp_err", 64'(arb_if.rsp_err), 64'(e.err));
                    chk("issue_count", 64'(issue_cnt), 64'(e.issues));
                    chk("fields_held", {arb_if.spi_cmd, arb_if.spi_addr, arb_if.spi_data},
                        {e.cmd, e.addr, e.wdata});
                    if (e.tmo) chk("timeout_latency", 64'(cyc - last_start_cyc), 64'(TIMEOUT + 1));
                end
                done_cnt++;
            end
        end
    end

    task automatic run_txn(input logic [1:0] mask,
                           input logic [7:0] c0, input logic [23:0] a0, input logic [31:0] d0,
                           input logic [7:0] c1, input logic [23:0] a1, input logic [31:0] d1,
                           input int fail, input int delay, input bit tmo, input bit stale,
                           input bit do_rst);
        exp_t e;
        logic w;
        bit   got;
        bit   fin;
        int   done0;
        int   acc_cyc;
        int   n;
        @(negedge clk);
        w    = (mask == 2'b11) ? rr_m : mask[1];
        rr_m = ~w;
        cur_cmd   = w ? c1 : c0;
        cur_addr  = w ? a1 : a0;
        cur_data  = w ? d1 : d0;
        cur_fail  = fail;
        cur_delay = delay;
        cur_tmo   = tmo;
        cur_stale = stale;
        issue_cnt = 0;
        first_start_cyc = -1;
        arb_if.req0_cmd  = c0;
        arb_if.req0_addr = a0;
        arb_if.req0_data = d0;
        arb_if.req1_cmd  = c1;
        arb_if.req1_addr = a1;
        arb_if.req1_data = d1;
        arb_if.req_valid = mask;
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!got) begin
                #1;
                if (arb_if.req_ready !== 2'b00) got = 1'b1;
                else @(negedge clk);
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL grant_wait actual=00 expected=%b", w ? 2'b10 : 2'b01);
            arb_if.req_valid = 2'b00;
            return;
        end
        chk("grant", 64'(arb_if.req_ready), w ? 64'd2 : 64'd1);
        e.owner = w;
        e.cmd   = cur_cmd;
        e.addr  = cur_addr;
        e.wdata = cur_data;
        e.tmo   = tmo;
        if (tmo) begin
            e.data = 32'd0; e.err = 2'b10; e.issues = 1;
        end else if (fail <= MAX_RETRY) begin
            e.data = cur_data; e.err = 2'b00; e.issues = fail + 1;
        end else begin
            e.data = cur_data; e.err = 2'b01; e.issues = MAX_RETRY + 1;
        end
        if (!do_rst) sb_q.push_back(e);
        done0 = done_cnt;
        @(posedge clk); #2;
        acc_cyc = cyc;
        if (do_rst) begin
            repeat (4) @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk); #1;
            chk_reset_vals("midrst");
            @(negedge clk);
            rst = 1'b0;
            arb_if.req_valid = 2'b00;
            rr_m = 1'b0;
            repeat (TIMEOUT + 8) @(posedge clk);
            #2;
            chk("no_rsp_after_rst", 64'(done_cnt - done0), 64'd0);
            return;
        end
        fin = 1'b0;
        n = 0;
        while (!fin && n < 200) begin
            chk("ready_busy", 64'(arb_if.req_ready), 64'd0);
            if (done_cnt != done0) fin = 1'b1;
            else begin
                @(posedge clk); #2;
                n++;
            end
        end
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL rsp_wait actual=none expected=rsp_valid");
        end
        chk("start_at_n_plus_1", 64'(first_start_cyc), 64'(acc_cyc));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        arb_if.req_valid = 2'b11;
        arb_if.req0_cmd  = 8'd0;  arb_if.req1_cmd  = 8'd0;
        arb_if.req0_addr = 24'd0; arb_if.req1_addr = 24'd0;
        arb_if.req0_data = 32'd0; arb_if.req1_data = 32'd0;
        arb_if.data_end  = 1'b0;
        arb_if.crc_ok    = 1'b0;
        arb_if.spi_resp  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;
        arb_if.req_valid = 2'b00;
        mon_en = 1'b1;
        eng_en = 1'b1;

        for (int i = 0; i < 4; i++)
            run_txn(2'b11, 8'($urandom), 24'($urandom), $urandom,
                    8'($urandom), 24'($urandom), $urandom, 0, 3, 1'b0, 1'b0, 1'b0);
        run_txn(2'b01, 8'h00, 24'h123456, 32'hF0F0A5A5,
                8'($urandom), 24'($urandom), $urandom, 0, 3, 1'b0, 1'b0, 1'b0);
        run_txn(2'b10, 8'($urandom), 24'($urandom), $urandom,
                8'hFF, 24'hABCDEF, 32'hDEADBEEF, 7, 4, 1'b0, 1'b0, 1'b0);
        run_txn(2'b01, 8'($urandom), 24'($urandom), $urandom,
                8'($urandom), 24'($urandom), $urandom, 1, 2, 1'b0, 1'b0, 1'b0);
        run_txn(2'b10, 8'($urandom), 24'($urandom), $urandom,
                8'($urandom), 24'($urandom), $urandom, 0, 3, 1'b1, 1'b0, 1'b0);
        run_txn(2'b01, 8'($urandom), 24'($urandom), $urandom,
                8'($urandom), 24'($urandom), $urandom, 0, TIMEOUT + 1, 1'b0, 1'b0, 1'b0);
        run_txn(2'b11, 8'($urandom), 24'($urandom), $urandom,
                8'($urandom), 24'($urandom), $urandom, 0, 3, 1'b0, 1'b1, 1'b0);
        run_txn(2'b01, 8'($urandom), 24'($urandom), $urandom,
                8'($urandom), 24'($urandom), $urandom, 0, 2, 1'b0, 1'b0, 1'b0);
        run_txn(2'b01, 8'($urandom), 24'($urandom), $urandom,
                8'($urandom), 24'($urandom), $urandom, 0, 3, 1'b1, 1'b0, 1'b1);
        run_txn(2'b11, 8'($urandom), 24'($urandom), $urandom,
                8'($urandom), 24'($urandom), $urandom, 0, 3, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            bit tmo_r;
            tmo_r = ($urandom_range(0, 7) == 0);
            run_txn(2'($urandom_range(1, 3)),
                    8'($urandom), 24'($urandom), $urandom,
                    8'($urandom), 24'($urandom), $urandom,
                    int'($urandom_range(0, 4)), int'($urandom_range(2, 8)),
                    tmo_r, !tmo_r && ($urandom_range(0, 7) == 0), 1'b0);
        end

        @(negedge clk);
        arb_if.req_valid = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
